// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions, schedule step and FSM state type
// for the iterative block engine.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, OUT} state_t;

    // Index 0 is the most significant word, matching the block and digest layout.
    typedef logic [0:15][31:0] win_t;
    typedef logic [0:7][31:0]  hash_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic hash_t iv_for(input logic m224);
        return m224 ? IV224 : IV256;
    endfunction

    // Slide the 16-word schedule window forward by r words; later extension
    // words feed on earlier ones so up to four can be produced per cycle.
    function automatic win_t sched_step(input win_t w, input int r);
        logic [31:0] ext [0:19];
        win_t        nw;
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < 4; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        case (r)
            2:       for (int i = 0; i < 16; i++) nw[i] = ext[i+2];
            4:       for (int i = 0; i < 16; i++) nw[i] = ext[i+4];
            default: for (int i = 0; i < 16; i++) nw[i] = ext[i+1];
        endcase
        return nw;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed as a..h with a
// in the top word.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  kt,
    input  logic [31:0]  wt,
    output logic [255:0] st_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;

    assign t1 = h + bsig1(e) + ch(e, f, g) + kt + wt;
    assign t2 = bsig0(a) + maj(a, b, c);

    assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_engine.sv
// Iterative multi-block SHA-256 engine with chained intermediate hash.
// Define SHA224_EN to add the mode_224 input and truncated SHA-224 output.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CLK = 1,
    parameter bit OUT_HOLD       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [255:0] fin_hash,
    output logic         busy,
    output logic [6:0]   round_idx_o,
    output logic         err_o
`ifdef SHA224_EN
    ,
    input  logic         mode_224
`endif
);

    localparam logic [6:0] LAST_RND = 7'(64 - ROUNDS_PER_CLK);
    localparam logic [6:0] RND_STEP = 7'(ROUNDS_PER_CLK);

    if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4)) begin : g_bad_rpc
        $error("ROUNDS_PER_CLK must be 1, 2 or 4");
    end

    state_t       state, state_nxt;
    win_t         w_q;
    hash_t        h_q, wv_q, sum, iv_sel;
    logic [255:0] fin_q, fin_sel, rnd_out;
    logic [6:0]   rnd;
    logic         first_q, last_q, chain_valid, use_iv, mode_q;

`ifdef SHA224_EN
    // Variant is chosen when a message starts (or is restarted from IV).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else if (state == IDLE && blk_valid && (blk_first || !chain_valid))
            mode_q <= mode_224;
    end
`else
    assign mode_q = 1'b0;
`endif

    assign use_iv  = first_q || !chain_valid;
    assign iv_sel  = iv_for(mode_q);
    assign fin_sel = mode_q ? {sum[0:6], 32'h0} : sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum[i] = h_q[i] + wv_q[i];
    end

    for (genvar g = 0; g < ROUNDS_PER_CLK; g++) begin : g_rnd
        logic [255:0] s_in;
        logic [255:0] s_out;
        if (g == 0) begin : g_head
            assign s_in = wv_q;
        end else begin : g_link
            assign s_in = g_rnd[g-1].s_out;
        end
        sha256_round u_round (
            .st_in  (s_in),
            .kt     (K[6'(rnd[5:0] + 6'(g))]),
            .wt     (w_q[g]),
            .st_out (s_out)
        );
    end
    assign rnd_out = g_rnd[ROUNDS_PER_CLK-1].s_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blk_valid) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (rnd == LAST_RND) state_nxt = UPDATE;
            UPDATE:  state_nxt = last_q ? OUT : IDLE;
            OUT:     if (!OUT_HOLD || hash_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rnd parks at 64 outside ROUND, so it drives round_idx_o directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q         <= '0;
            h_q         <= '0;
            wv_q        <= '0;
            fin_q       <= '0;
            rnd         <= 7'd64;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            chain_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        w_q     <= blk_data;
                        first_q <= blk_first;
                        last_q  <= blk_last;
                    end
                end
                LOAD: begin
                    wv_q <= use_iv ? iv_sel : h_q;
                    if (use_iv) h_q <= iv_sel;
                    rnd  <= 7'd0;
                end
                ROUND: begin
                    wv_q <= rnd_out;
                    w_q  <= sched_step(w_q, ROUNDS_PER_CLK);
                    rnd  <= rnd + RND_STEP;
                end
                UPDATE: begin
                    h_q         <= sum;
                    chain_valid <= !last_q;
                    if (last_q) fin_q <= fin_sel;
                end
                default: ;
            endcase
        end
    end

    assign blk_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign hash_valid  = (state == OUT);
    assign fin_hash    = fin_q;
    assign round_idx_o = rnd;
    assign err_o       = (state == LOAD) && !first_q && !chain_valid;

endmodule
